// File: rtl/t10_lcd_pkg.sv
// Shared types, command bytes and byte-selection helpers for the 16x2 character LCD writer.
package t10_lcd_pkg;

  localparam int unsigned ROW_W     = 128;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned N_INIT    = 4;
  localparam int unsigned N_REFRESH = 34;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_ROW0     = 8'h80;
  localparam logic [7:0] LCD_ROW1     = 8'hC0;

  typedef enum logic [1:0] {POWERUP, INIT, REFRESH, IDLE} lcd_state_e;
  typedef enum logic [1:0] {SETUP, PULSE, WAIT} byte_phase_e;

  typedef struct packed {
    logic       rs;
    logic       long_wait;
    logic [7:0] data;
  } lcd_byte_t;

  // Column 0 sits in the top byte of a row, so the byte offset is (15 - col).
  function automatic logic [7:0] row_char(input logic [ROW_W-1:0] row, input logic [3:0] col);
    logic [6:0] lsb;
    lsb = {~col, 3'b000};
    return row[lsb +: 8];
  endfunction

  function automatic lcd_byte_t init_byte(input logic [1:0] i);
    lcd_byte_t b;
    b.rs        = 1'b0;
    b.long_wait = 1'b0;
    case (i)
      2'd0:    b.data = LCD_FUNC_SET;
      2'd1:    b.data = LCD_DISP_ON;
      2'd2:    begin b.data = LCD_CLEAR; b.long_wait = 1'b1; end
      default: b.data = LCD_ENTRY;
    endcase
    return b;
  endfunction

  // Refresh order: ROW0, 16 top chars, ROW1, 16 bottom chars.
  function automatic lcd_byte_t refresh_byte(input logic [IDX_W-1:0] idx,
                                             input logic [ROW_W-1:0] sh_top,
                                             input logic [ROW_W-1:0] sh_bot);
    lcd_byte_t b;
    b.long_wait = 1'b0;
    if (idx == IDX_W'(0)) begin
      b.rs = 1'b0; b.data = LCD_ROW0;
    end else if (idx <= IDX_W'(16)) begin
      b.rs = 1'b1; b.data = row_char(sh_top, 4'(idx - 6'd1));
    end else if (idx == IDX_W'(17)) begin
      b.rs = 1'b0; b.data = LCD_ROW1;
    end else begin
      b.rs = 1'b1; b.data = row_char(sh_bot, 4'(idx - 6'd18));
    end
    return b;
  endfunction

endpackage

// File: rtl/t10_lcd_writer_if.sv
// Row content from the host formatter plus the LCD pad bus and busy flag.
interface t10_lcd_writer_if;
  import t10_lcd_pkg::*;

  logic [ROW_W-1:0] top;
  logic [ROW_W-1:0] bottom;
  logic             lcd_en;
  logic             lcd_rs;
  logic             lcd_rw;
  logic [7:0]       lcd_data;
  logic             busy;

  modport master (output top, bottom, input lcd_en, lcd_rs, lcd_rw, lcd_data, busy);
  modport slave  (input top, bottom, output lcd_en, lcd_rs, lcd_rw, lcd_data, busy);
endinterface

// File: rtl/t10_lcd_byte_tx.sv
// One LCD bus write: setup cycle, enable pulse, then a settle wait; rs/data held throughout.
module t10_lcd_byte_tx
  import t10_lcd_pkg::*;
#(
  parameter int unsigned EN_PULSE_CYC   = 10,
  parameter int unsigned CMD_WAIT_CYC   = 1000,
  parameter int unsigned CLEAR_WAIT_CYC = 50000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  byte_phase_e      phase, phase_nxt;
  logic             active, active_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             long_q, long_nxt;
  logic             en_q, en_nxt;
  logic             rs_q, rs_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             done_q, done_nxt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase  <= SETUP;
      active <= 1'b0;
      cnt    <= '0;
      long_q <= 1'b0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      active <= active_nxt;
      cnt    <= cnt_nxt;
      long_q <= long_nxt;
      en_q   <= en_nxt;
      rs_q   <= rs_nxt;
      data_q <= data_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    phase_nxt  = phase;
    active_nxt = active;
    cnt_nxt    = cnt;
    long_nxt   = long_q;
    en_nxt     = 1'b0;
    rs_nxt     = rs_q;
    data_nxt   = data_q;

    if (active) begin
      case (phase)
        SETUP: begin
          phase_nxt = PULSE;
          cnt_nxt   = CNT_W'(EN_PULSE_CYC - 1);
          en_nxt    = 1'b1;
        end
        PULSE: begin
          if (cnt == '0) begin
            phase_nxt = WAIT;
            cnt_nxt   = long_q ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
            en_nxt  = 1'b1;
          end
        end
        default: begin
          if (cnt == '0) active_nxt = 1'b0;
          else           cnt_nxt    = cnt - CNT_W'(1);
        end
      endcase
    end

    // A new byte may be accepted in the final wait cycle for gapless back-to-back writes.
    if (start && (!active || done_q)) begin
      active_nxt = 1'b1;
      phase_nxt  = SETUP;
      cnt_nxt    = '0;
      en_nxt     = 1'b0;
      rs_nxt     = rs;
      data_nxt   = data;
      long_nxt   = long_wait;
    end

    done_nxt = active_nxt && (phase_nxt == WAIT) && (cnt_nxt == '0);
  end

  assign done     = done_q;
  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/t10_lcd_writer.sv
// Sequencer: power-up delay, HD44780 init, then full two-row refresh whenever the rows change.
module t10_lcd_writer
  import t10_lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 500000,
  parameter int unsigned EN_PULSE_CYC   = 10,
  parameter int unsigned CMD_WAIT_CYC   = 1000,
  parameter int unsigned CLEAR_WAIT_CYC = 50000
) (
  input  logic              clk,
  input  logic              nRst,
  t10_lcd_writer_if.slave   bus
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > EN_PULSE_CYC) ? POWERUP_CYC : EN_PULSE_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  lcd_state_e       state, state_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             kick, kick_nxt;
  logic [ROW_W-1:0] shadow_top, shadow_top_nxt;
  logic [ROW_W-1:0] shadow_bot, shadow_bot_nxt;
  logic             busy_q;
  lcd_byte_t        cur_c;
  logic             tx_start_c;
  logic             tx_done;
  logic             rows_differ_c;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= POWERUP;
      pcnt       <= '0;
      idx        <= '0;
      kick       <= 1'b0;
      shadow_top <= '0;
      shadow_bot <= '0;
      busy_q     <= 1'b1;
    end else begin
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      idx        <= idx_nxt;
      kick       <= kick_nxt;
      shadow_top <= shadow_top_nxt;
      shadow_bot <= shadow_bot_nxt;
      busy_q     <= (state_nxt != IDLE);
    end
  end

  assign rows_differ_c = ({bus.top, bus.bottom} != {shadow_top, shadow_bot});

  // idx is the next byte to issue; kick marks the first cycle of a sending state.
  always_comb begin
    state_nxt      = state;
    pcnt_nxt       = pcnt;
    idx_nxt        = idx;
    kick_nxt       = 1'b0;
    shadow_top_nxt = shadow_top;
    shadow_bot_nxt = shadow_bot;
    tx_start_c     = 1'b0;
    cur_c          = (state == INIT) ? init_byte(idx[1:0]) : refresh_byte(idx, shadow_top, shadow_bot);

    case (state)
      POWERUP: begin
        if (pcnt == CNT_W'(POWERUP_CYC - 1)) begin
          state_nxt = INIT;
          kick_nxt  = 1'b1;
          idx_nxt   = '0;
        end else begin
          pcnt_nxt = pcnt + CNT_W'(1);
        end
      end
      INIT: begin
        if (kick || (tx_done && idx != IDX_W'(N_INIT))) begin
          tx_start_c = 1'b1;
          idx_nxt    = idx + IDX_W'(1);
        end else if (tx_done) begin
          state_nxt = REFRESH;
          kick_nxt  = 1'b1;
          idx_nxt   = '0;
        end
      end
      REFRESH: begin
        if (kick) begin
          shadow_top_nxt = bus.top;
          shadow_bot_nxt = bus.bottom;
          tx_start_c     = 1'b1;
          idx_nxt        = idx + IDX_W'(1);
        end else if (tx_done) begin
          if (idx != IDX_W'(N_REFRESH)) begin
            tx_start_c = 1'b1;
            idx_nxt    = idx + IDX_W'(1);
          end else if (rows_differ_c) begin
            kick_nxt = 1'b1;
            idx_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        if (rows_differ_c) begin
          state_nxt = REFRESH;
          kick_nxt  = 1'b1;
          idx_nxt   = '0;
        end
      end
    endcase
  end

  t10_lcd_byte_tx #(
    .EN_PULSE_CYC  (EN_PULSE_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC),
    .CNT_W         (CNT_W)
  ) u_byte_tx (
    .clk      (clk),
    .nRst     (nRst),
    .start    (tx_start_c),
    .rs       (cur_c.rs),
    .data     (cur_c.data),
    .long_wait(cur_c.long_wait),
    .done     (tx_done),
    .lcd_en   (bus.lcd_en),
    .lcd_rs   (bus.lcd_rs),
    .lcd_data (bus.lcd_data)
  );

  assign bus.lcd_rw = 1'b0;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_t10_lcd_writer.sv
// Directed bench for t10_lcd_writer: power-up/init, refresh content, change handling and reset.
module tb_t10_lcd_writer;

  localparam int unsigned P_PWR = 16;
  localparam int unsigned P_EN  = 2;
  localparam int unsigned P_CMD = 4;
  localparam int unsigned P_CLR = 8;

  localparam logic [127:0] TOP0 = {8'h57, {15{8'h20}}};
  localparam logic [127:0] BOT0 = {16{8'h5F}};
  localparam logic [127:0] BOT1 = "0123456789ABCDEF";

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  t10_lcd_writer_if bus();

  t10_lcd_writer #(
    .POWERUP_CYC(P_PWR), .EN_PULSE_CYC(P_EN), .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0] seen[$];
  int         rw_bad = 0, stable_bad = 0, width_bad = 0, run_len = 0;
  logic       prev_en = 1'b0;
  logic [8:0] prev_byte = 9'h000;
  logic [127:0] top1, top2;

  // Bus monitor: logs {rs,data} at each enable rise and tracks bus-wide invariants.
  always @(negedge clk) begin
    if (bus.lcd_rw !== 1'b0) rw_bad++;
    if (!nRst) begin
      seen.delete();
      prev_en = 1'b0;
      run_len = 0;
    end else begin
      if (bus.lcd_en === 1'b1) begin
        if (!prev_en) begin
          seen.push_back({bus.lcd_rs, bus.lcd_data});
          run_len = 1;
        end else begin
          run_len++;
          if ({bus.lcd_rs, bus.lcd_data} !== prev_byte) stable_bad++;
        end
      end else if (prev_en && run_len != P_EN) begin
        width_bad++;
      end
      prev_en   = (bus.lcd_en === 1'b1);
      prev_byte = {bus.lcd_rs, bus.lcd_data};
    end
  end

  function automatic logic [8:0] exp_byte(input int k, input logic [127:0] t, input logic [127:0] b);
    if (k == 0)  return 9'h080;
    if (k <= 16) return {1'b1, t[127-8*(k-1) -: 8]};
    if (k == 17) return 9'h0C0;
    return {1'b1, b[127-8*(k-18) -: 8]};
  endfunction

  task automatic wait_busy_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] init_exp [4];
    int gap_exp [3];
    int low, busy_bad, hi, gap;
    bit got;
    init_exp = '{8'h38, 8'h0C, 8'h01, 8'h06};
    gap_exp  = '{P_CMD, P_CMD, P_CLR};
    nRst = 1'b0;
    bus.top = TOP0;
    bus.bottom = BOT0;
    repeat (3) @(negedge clk);
    checks++; if (bus.lcd_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", bus.lcd_en); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", bus.lcd_data); end
    checks++; if (bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs: got %b expected 0", bus.lcd_rs); end
    #2 nRst = 1'b1;
    low = 0; busy_bad = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.lcd_en === 1'b1) begin got = 1'b1; break; end
      low++;
      if (bus.busy !== 1'b1) busy_bad++;
    end
    checks++; if (!got || low < P_PWR) begin errors++; $display("FAIL powerup_quiet: en low %0d cycles (seen=%0d) expected >= %0d", low, got, P_PWR); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL powerup_busy: busy low %0d cycles expected 0", busy_bad); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
          if (bus.lcd_en === 1'b1) begin got = 1'b1; break; end
          @(negedge clk);
        end
        checks++; if (!got) begin errors++; $display("FAIL init_pulse%0d: no enable pulse got 0 expected 1", k); end
      end
      checks++;
      if ({bus.lcd_rs, bus.lcd_data} !== {1'b0, init_exp[k]}) begin
        errors++; $display("FAIL init_byte%0d: got %h expected %h", k, {bus.lcd_rs, bus.lcd_data}, {1'b0, init_exp[k]});
      end
      hi = 0;
      for (int i = 0; i < 50 && bus.lcd_en === 1'b1; i++) begin hi++; @(negedge clk); end
      checks++; if (hi != P_EN) begin errors++; $display("FAIL init_width%0d: got %0d expected %0d", k, hi, P_EN); end
      if (k < 3) begin
        gap = 0;
        for (int i = 0; i < 100 && bus.lcd_en === 1'b0 && bus.lcd_data === init_exp[k]; i++) begin
          gap++; @(negedge clk);
        end
        checks++; if (gap != gap_exp[k]) begin errors++; $display("FAIL init_gap%0d: got %0d expected %0d", k, gap, gap_exp[k]); end
      end
    end
  endtask

  task automatic test_first_refresh();
    bit ok;
    int act, busy_bad;
    wait_busy_low(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL refresh1_done: busy stuck got 1 expected 0"); end
    checks++; if (seen.size() != 38) begin errors++; $display("FAIL refresh1_count: got %0d expected 38", seen.size()); end
    for (int k = 0; k < 34; k++) begin
      if (seen.size() > 4 + k) begin
        checks++;
        if (seen[4+k] !== exp_byte(k, TOP0, BOT0)) begin
          errors++; $display("FAIL refresh1_byte%0d: got %h expected %h", k, seen[4+k], exp_byte(k, TOP0, BOT0));
        end
      end
    end
    act = 0; busy_bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.lcd_en !== 1'b0) act++;
      if (bus.busy !== 1'b0) busy_bad++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL idle_quiet: en high %0d cycles expected 0", act); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL idle_busy: busy high %0d cycles expected 0", busy_bad); end
  endtask

  task automatic test_idle_change();
    bit ok;
    seen.delete();
    @(negedge clk);
    top1 = TOP0;
    top1[7:0] = 8'h41;
    bus.top = top1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL chg_busy_before: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL chg_busy_rise: got %b expected 1", bus.busy); end
    wait_busy_low(2000, ok);
    checks++; if (!ok || seen.size() != 34) begin errors++; $display("FAIL chg_count: got %0d (done=%0d) expected 34", seen.size(), ok); end
    for (int k = 0; k < 34; k++) begin
      if (seen.size() > k) begin
        checks++;
        if (seen[k] !== exp_byte(k, top1, BOT0)) begin
          errors++; $display("FAIL chg_byte%0d: got %h expected %h", k, seen[k], exp_byte(k, top1, BOT0));
        end
      end
    end
    if (seen.size() > 16) begin
      checks++; if (seen[16] !== 9'h141) begin errors++; $display("FAIL chg_last_top: got %h expected 141", seen[16]); end
    end
  endtask

  task automatic test_change_mid_refresh();
    bit ok, got;
    seen.delete();
    @(negedge clk);
    top2 = {8'h42, top1[119:0]};
    bus.top = top2;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (seen.size() >= 5) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_reach5: got %0d bytes expected 5", seen.size()); end
    bus.bottom = BOT1;
    wait_busy_low(4000, ok);
    checks++; if (!ok || seen.size() != 68) begin errors++; $display("FAIL mid_no_gap: got %0d bytes at idle (done=%0d) expected 68", seen.size(), ok); end
    for (int k = 0; k < 68; k++) begin
      if (seen.size() > k) begin
        checks++;
        if (seen[k] !== exp_byte(k % 34, top2, (k < 34) ? BOT0 : BOT1)) begin
          errors++; $display("FAIL mid_byte%0d: got %h expected %h", k, seen[k], exp_byte(k % 34, top2, (k < 34) ? BOT0 : BOT1));
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit ok, got;
    int low;
    logic [8:0] init9 [4];
    init9 = '{9'h038, 9'h00C, 9'h001, 9'h006};
    @(negedge clk);
    bus.top = TOP0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.lcd_en === 1'b1) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL rstp_pulse: no enable pulse got 0 expected 1"); end
    #2 nRst = 1'b0;
    #1;
    checks++; if (bus.lcd_en !== 1'b0) begin errors++; $display("FAIL rstp_en: got %b expected 0", bus.lcd_en); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstp_busy: got %b expected 1", bus.busy); end
    repeat (2) @(negedge clk);
    #2 nRst = 1'b1;
    low = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.lcd_en === 1'b1) begin got = 1'b1; break; end
      low++;
    end
    checks++; if (!got || low < P_PWR) begin errors++; $display("FAIL rstp_powerup: en low %0d cycles (seen=%0d) expected >= %0d", low, got, P_PWR); end
    wait_busy_low(3000, ok);
    checks++; if (!ok || seen.size() != 38) begin errors++; $display("FAIL rstp_count: got %0d (done=%0d) expected 38", seen.size(), ok); end
    for (int k = 0; k < 4; k++) begin
      if (seen.size() > k) begin
        checks++; if (seen[k] !== init9[k]) begin errors++; $display("FAIL rstp_init%0d: got %h expected %h", k, seen[k], init9[k]); end
      end
    end
    for (int k = 0; k < 34; k++) begin
      if (seen.size() > 4 + k) begin
        checks++;
        if (seen[4+k] !== exp_byte(k, TOP0, BOT1)) begin
          errors++; $display("FAIL rstp_byte%0d: got %h expected %h", k, seen[4+k], exp_byte(k, TOP0, BOT1));
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++; if (rw_bad != 0) begin errors++; $display("FAIL rw_zero: got %0d nonzero samples expected 0", rw_bad); end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL bus_stable: got %0d changes under enable expected 0", stable_bad); end
    checks++; if (width_bad != 0) begin errors++; $display("FAIL pulse_width: got %0d bad pulses expected 0", width_bad); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus.top = '0;
    bus.bottom = '0;
    test_reset();
    test_first_refresh();
    test_idle_change();
    test_change_mid_refresh();
    test_reset_mid_pulse();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
